multicycle_ctrl: RTL
====================

# multicycle_ctrl

Multicycle control unit with PC, instruction register and PSW flag register. It sits directly upstream of RFplusALU. It fetches a 16-bit instruction, holds it on `Ins`, and sequences FETCH/DECODE/EXE/MEM/WB. In each state it drives the RFplusALU control bundle and the memory strobes. It also updates the PC for sequential flow, branches and jumps.

## Interface
- No parameters; datapath fixed at 16 bits.
- clk  in  1  system clock, all state on rising edge
- Reset  in  1  asynchronous, active-low reset
- InsIn  in  16  instruction memory read data at address PC
- C, Z, N  in  1 each  RFplusALU combinational flags of current EXE result
- RegA, RegB  in  16 each  RF read port A (ins[7:5]) / port B values
- MemReady  in  1  data memory completes access this cycle
- PC  out  16  program counter (instruction address)
- Ins  out  16  instruction register to RFplusALU
- WBRF, WBresource, RBresource, OprandB, LI, Buff_IDEXE  out  1 each  RFplusALU ID/WB controls
- PSW_C, ALUop, Flag  out  1 each  RFplusALU EXE control code
- LinkWB  out  1  select PC onto WBData (JAL link)
- MemRd, MemWr  out  1 each  data memory strobes
- OutEn  out  1  load OutR
- FlagC, FlagZ, FlagN  out  1 each  stored PSW (FlagC is ALU carry-in)
- Halted  out  1  HALT state indicator

## Operation
- Fields: op=ins[15:11], rd=ins[10:8], rm=ins[7:5], rn=ins[4:2], imm5=ins[4:0], imm8=ins[7:0], off11=ins[10:0].
- Opcodes: 00000 MOV, 00001 ADD, 00010 ADC, 00011 SUB, 00100 SBB, 00101 CMP, 00110 ADDI, 00111 SUBI, 01000 LHI, 01001 LLI, 01010 LDR_RI, 01011 LDR_RR, 01100 STR_RI, 01101 STR_RR, 01110 OUTR, 10000 JMP, 10010 BZ, 10011 JAL, 10100 JAL_RR, 10101 JR, 11100 HLT. All others are NOP: FETCH, DECODE, FETCH.
- FETCH: Ins<=InsIn, PC<=PC+1 (16-bit wrap, FFFF to 0000). No control asserted.
- DECODE, controls given as {WBRF,WBresource,RBresource,OprandB,LI,Buff_IDEXE}, x driven 0:
  - RR ALU ops and MOV: 000001.
  - RI ALU ops, LDR_RI, STR_RI: 000101.
  - LDR_RR, STR_RR: 000001.
  - LHI: 001001; next state WB.
  - LLI: 000011; next state WB.
  - OUTR: OutEn=1; next state FETCH.
- DECODE control flow (next state FETCH for all):
  - JMP: PC<=PC+sext(off11).
  - BZ: if FlagZ, PC<=PC+sext(imm8).
  - JAL: WBRF=WBresource=LinkWB=1, PC<=PC+sext(imm8).
  - JAL_RR: link as JAL, PC<=RegA.
  - JR: RBresource=1, PC<=RegB.
  - HLT: go to HALT.
- EXE, {PSW_C,ALUop,Flag}:
  - 100 for ADD, ADDI, LDR*, STR*.
  - 101 for ADC.
  - 010 for SUB, SUBI, CMP.
  - 011 for SBB.
  - 000 for MOV (pass A).
  - STR* also RBresource=1.
- EXE flag update: ADD/ADC/SUB/SBB/CMP/ADDI/SUBI load FlagC/Z/N from C/Z/N on exit edge; MOV, LDR and STR do not.
- EXE next state: CMP to FETCH; LDR/STR to MEM; others to WB.
- MEM: LDR holds MemRd=1, STR holds MemWr=1 (STR also RBresource=1) until MemReady=1. LDR then goes to WB; STR to FETCH.
- WB: WBRF=1; WBresource=0 for LDR, 1 otherwise; next state FETCH.
- HALT: all controls 0, Halted=1, PC/Ins frozen; exit only by Reset.

## Timing
- Reset low, asynchronous: state FETCH, PC=0000, Ins=0000, FlagC/Z/N=0. All controls, strobes and Halted are 0. First fetch at first rising edge after release.
- Controls are Moore outputs of state+Ins, valid throughout the state cycle.
- Cycles per instruction:
  - Jumps, BZ, JAL*, OUTR, NOP: 2.
  - LHI, LLI, CMP: 3.
  - ALU ops, MOV: 4.
  - STR: 4+w; LDR: 5+w (w = MEM wait cycles).
- Branch offsets add to the already-incremented PC; link value is PC during DECODE (= instruction address + 1).
- MemReady outside MEM is ignored. MemReady=1 on MEM entry gives zero wait.
- Reset mid-MEM drops MemRd/MemWr immediately (asynchronous).

## Test plan
- Reset asserted during LDR MEM wait -> MemRd falls to 0 without waiting for an edge; PC=0000, Ins=0000; fetch restarts at 0.
- ADD (C=1 at EXE) then ADC -> ADD EXE code 100; FlagC=1 after ADD EXE; ADC EXE code 101; WB WBRF=1, WBresource=1; ADD and ADC 4 cycles each.
- LDR_RI with MemReady low 3 cycles -> MemRd high 4 cycles; WB WBresource=0; total 8 cycles; flags unchanged.
- BZ imm8=FE at address 0005, FlagZ=1 -> PC=0004. Same with FlagZ=0 -> PC=0006.
- JAL_RR at address 0010, RegA=1234 -> DECODE WBRF=LinkWB=1 with PC=0011; next PC=1234.
- Ins=NOP at PC=FFFF -> PC wraps to 0000. HLT -> Halted=1, PC frozen over 10 cycles.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle control unit: PC, instruction register and PSW flags, sequencing
// FETCH/DECODE/EXE/MEM/WB and driving the RFplusALU control bundle.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        Reset,
  input  logic [15:0] InsIn,
  input  logic        C,
  input  logic        Z,
  input  logic        N,
  input  logic [15:0] RegA,
  input  logic [15:0] RegB,
  input  logic        MemReady,
  output logic [15:0] PC,
  output logic [15:0] Ins,
  output logic        WBRF,
  output logic        WBresource,
  output logic        RBresource,
  output logic        OprandB,
  output logic        LI,
  output logic        Buff_IDEXE,
  output logic        PSW_C,
  output logic        ALUop,
  output logic        Flag,
  output logic        LinkWB,
  output logic        MemRd,
  output logic        MemWr,
  output logic        OutEn,
  output logic        FlagC,
  output logic        FlagZ,
  output logic        FlagN,
  output logic        Halted
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXE, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [4:0] OP_MOV    = 5'b00000;
  localparam logic [4:0] OP_ADD    = 5'b00001;
  localparam logic [4:0] OP_ADC    = 5'b00010;
  localparam logic [4:0] OP_SUB    = 5'b00011;
  localparam logic [4:0] OP_SBB    = 5'b00100;
  localparam logic [4:0] OP_CMP    = 5'b00101;
  localparam logic [4:0] OP_ADDI   = 5'b00110;
  localparam logic [4:0] OP_SUBI   = 5'b00111;
  localparam logic [4:0] OP_LHI    = 5'b01000;
  localparam logic [4:0] OP_LLI    = 5'b01001;
  localparam logic [4:0] OP_LDR_RI = 5'b01010;
  localparam logic [4:0] OP_LDR_RR = 5'b01011;
  localparam logic [4:0] OP_STR_RI = 5'b01100;
  localparam logic [4:0] OP_STR_RR = 5'b01101;
  localparam logic [4:0] OP_OUTR   = 5'b01110;
  localparam logic [4:0] OP_JMP    = 5'b10000;
  localparam logic [4:0] OP_BZ     = 5'b10010;
  localparam logic [4:0] OP_JAL    = 5'b10011;
  localparam logic [4:0] OP_JALRR  = 5'b10100;
  localparam logic [4:0] OP_JR     = 5'b10101;
  localparam logic [4:0] OP_HLT    = 5'b11100;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ins_q, ins_d;
  logic [2:0]  flags_q, flags_d;  // {C,Z,N}

  logic [4:0]  op;
  logic        is_ri, is_ldr, is_str, is_exe, is_flagop;
  logic signed [15:0] off11_s, imm8_s;

  assign op        = ins_q[15:11];
  assign is_ldr    = (op == OP_LDR_RI) || (op == OP_LDR_RR);
  assign is_str    = (op == OP_STR_RI) || (op == OP_STR_RR);
  assign is_ri     = (op == OP_ADDI) || (op == OP_SUBI) || (op == OP_LDR_RI) || (op == OP_STR_RI);
  assign is_exe    = (op <= OP_SUBI) || is_ldr || is_str;
  assign is_flagop = (op >= OP_ADD) && (op <= OP_SUBI);
  assign off11_s   = {{5{ins_q[10]}}, ins_q[10:0]};
  assign imm8_s    = {{8{ins_q[7]}}, ins_q[7:0]};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ins_d      = ins_q;
    flags_d    = flags_q;
    WBRF       = 1'b0;
    WBresource = 1'b0;
    RBresource = 1'b0;
    OprandB    = 1'b0;
    LI         = 1'b0;
    Buff_IDEXE = 1'b0;
    PSW_C      = 1'b0;
    ALUop      = 1'b0;
    Flag       = 1'b0;
    LinkWB     = 1'b0;
    MemRd      = 1'b0;
    MemWr      = 1'b0;
    OutEn      = 1'b0;
    Halted     = 1'b0;
    case (state_q)
      S_FETCH: begin
        ins_d   = InsIn;
        pc_d    = pc_q + 16'd1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d = S_FETCH;
        if (is_exe) begin
          Buff_IDEXE = 1'b1;
          OprandB    = is_ri;
          state_d    = S_EXE;
        end
        // pc_q already points past this instruction: it is both branch base and link value
        case (op)
          OP_LHI:   begin RBresource = 1'b1; Buff_IDEXE = 1'b1; state_d = S_WB; end
          OP_LLI:   begin LI = 1'b1; Buff_IDEXE = 1'b1; state_d = S_WB; end
          OP_OUTR:  OutEn = 1'b1;
          OP_JMP:   pc_d = pc_q + off11_s;
          OP_BZ:    if (flags_q[1]) pc_d = pc_q + imm8_s;
          OP_JAL:   begin WBRF = 1'b1; WBresource = 1'b1; LinkWB = 1'b1; pc_d = pc_q + imm8_s; end
          OP_JALRR: begin WBRF = 1'b1; WBresource = 1'b1; LinkWB = 1'b1; pc_d = RegA; end
          OP_JR:    begin RBresource = 1'b1; pc_d = RegB; end
          OP_HLT:   state_d = S_HALT;
          default:  ;
        endcase
      end
      S_EXE: begin
        case (op)
          OP_ADD, OP_ADDI, OP_LDR_RI, OP_LDR_RR, OP_STR_RI, OP_STR_RR: PSW_C = 1'b1;
          OP_ADC:                 begin PSW_C = 1'b1; Flag = 1'b1; end
          OP_SUB, OP_SUBI, OP_CMP: ALUop = 1'b1;
          OP_SBB:                 begin ALUop = 1'b1; Flag = 1'b1; end
          default:                ;
        endcase
        RBresource = is_str;
        if (is_flagop) flags_d = {C, Z, N};
        if (op == OP_CMP)          state_d = S_FETCH;
        else if (is_ldr || is_str) state_d = S_MEM;
        else                       state_d = S_WB;
      end
      S_MEM: begin
        MemRd      = is_ldr;
        MemWr      = is_str;
        RBresource = is_str;
        if (MemReady) state_d = is_ldr ? S_WB : S_FETCH;
      end
      S_WB: begin
        WBRF       = 1'b1;
        WBresource = !is_ldr;
        state_d    = S_FETCH;
      end
      S_HALT:  Halted = 1'b1;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_FETCH;
      pc_q    <= 16'h0000;
      ins_q   <= 16'h0000;
      flags_q <= 3'b000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ins_q   <= ins_d;
      flags_q <= flags_d;
    end
  end

  assign PC    = pc_q;
  assign Ins   = ins_q;
  assign FlagC = flags_q[2];
  assign FlagZ = flags_q[1];
  assign FlagN = flags_q[0];

endmodule
